led_s2p_rx: RTL and testbench
=============================

Name: led_s2p_rx

Overview:
- Deserialiser for the serial LED frame stream (sclk/sout/sclrn/EN) that the LED parallel-to-serial stage produces.
- Oversamples the slow serial lines with the system clock and rebuilds the parallel word (e.g. the 16-bit RevCounter value).
- Presents the word with a one-cycle valid strobe and flags malformed frames.
- Used as an on-chip loopback checker and as the LED shift-chain model in the board-level bench.

Parameters:
- DATA_BITS, 16, frame length in bits.
- DATA_COUNT_BITS, 5, width of the received-bit counter; must hold DATA_BITS+1.
- DIR, 0, bit order. 0 = first received bit lands in PData[DATA_BITS-1] (MSB first). 1 = first received bit lands in PData[0].

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- sclk  in  1  serial clock; data is captured on its rising edge.
- sout  in  1  serial data.
- sclrn  in  1  active-low frame clear.
- EN  in  1  latch strobe; a rising edge ends the frame.
- PData  out  DATA_BITS  last good frame.
- valid  out  1  one-cycle pulse when PData updates.
- frame_err  out  1  one-cycle pulse on a short frame.
- ovf  out  1  one-cycle pulse on an extra bit.
- busy  out  1  high when state is SHIFT or FULL.

Behaviour:
- Clock and reset are decided: one clock; reset is synchronous and active-low (rstn sampled on the clk rising edge).
- Reset (rstn=0 at a clk edge): the following are cleared:
  - PData=0, valid=0, frame_err=0, ovf=0, busy=0
  - shift register=0, bit count=0
  - all synchroniser flops=0 (sclrn and EN synchronisers reset to 1)
  - state=IDLE
- A reset mid-frame discards the partial frame; no error pulse.
- Input sync: sclk, sout, sclrn and EN each pass through two flops. sclk and EN get a third flop for edge detection.
- sclk rise is detected when sync=1 and delayed=0. The sout sample is taken from its synchroniser stage aligned to that detection.
- Latency: sclk input rise to shift-register update is 3 clk. EN input rise to valid/frame_err is 3 clk; PData updates in the same cycle as valid.
- Input constraint: sout must be stable for at least 3 clk either side of an sclk rise. sclk and EN high/low times must each be at least 3 clk.
- Shift (DIR=0): shreg <= {shreg[DATA_BITS-2:0], bit}.
- Shift (DIR=1): shreg <= {bit, shreg[DATA_BITS-1:1]}.
- FSM IDLE: on an sclk rise, shift, set cnt=1 and go to SHIFT. On an EN rise, pulse frame_err (empty frame) and stay in IDLE.
- FSM SHIFT: each sclk rise shifts and does cnt+1; when cnt reaches DATA_BITS, go to FULL.
  - EN rise in SHIFT: pulse frame_err, PData unchanged, clear cnt, go to IDLE.
- FSM FULL: an sclk rise pulses ovf; shreg and cnt are unchanged and the extra bit is dropped.
  - EN rise in FULL: PData <= shreg, pulse valid, clear cnt, go to IDLE.
- sclrn (synced) low: clears shreg and cnt and goes to IDLE. It has priority over sclk and EN edges in the same cycle, and no pulses are emitted.
- Simultaneous sclk rise and EN rise: the shift is applied first, and the frame check uses the post-shift count. In SHIFT with cnt=DATA_BITS-1, this counts as a complete frame and produces valid.
- Pulse exclusivity: valid and frame_err are mutually exclusive. ovf may coincide with valid only in the simultaneous case from FULL.

Decomposition:
- Shared package holds:
  - state encoding IDLE=2'd0, SHIFT=2'd1, FULL=2'd2
  - the DIR_MSB_FIRST=0 and DIR_LSB_FIRST=1 constants
- One natural sub-module: sync_edge (2-flop synchroniser plus rising-edge detector with a configurable reset value), instantiated for sclk and EN. sout and sclrn use its sync output only.

Test Plan:
- Full frame, DIR=0: reset, then 16 bits of 0xA5C3 MSB first, then EN rise → PData=16'hA5C3, valid high exactly 1 clk, 3 clk after the EN rise; frame_err=0; busy=0 afterwards.
- Full frame, DIR=1: 16 bits of 0x1234 LSB first, then EN rise → PData=16'h1234, valid 1 clk.
- Short frame: 10 bits, then EN rise → frame_err 1 clk, valid=0, PData keeps its prior value 16'hA5C3, state IDLE.
- Overflow: 17 bits of 0xFFFF followed by a 0, then EN → ovf 1 clk on the 17th bit; PData=16'hFFFF, valid 1 clk.
- Clear and reset mid-operation:
  - sclrn low after 8 bits, then a fresh 16-bit 0x00FF frame plus EN → PData=16'h00FF with no error pulses.
  - rstn=0 for 1 clk after 5 bits → all outputs 0 on the next cycle.
- Simultaneous events: EN rise in the same clk as the 16th sclk rise → valid, PData equals the full word. EN rise together with sclrn low → no valid, no frame_err.

Source files
------------

// File: rtl/led_s2p_rx_pkg.sv
// Shared definitions for the LED serial-to-parallel receiver: FSM states and bit-order selectors.
package led_s2p_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int DIR_MSB_FIRST = 0;
  localparam int DIR_LSB_FIRST = 1;

endpackage

// File: rtl/led_s2p_rx_sync_edge.sv
// Two-flop synchroniser with a third flop for rising-edge detection; reset value selectable.
// Latency: input to sync/rise is 2 clk; no backpressure.
module led_s2p_rx_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic sync,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/led_s2p_rx.sv
// Oversampling deserialiser for the LED sclk/sout/sclrn/EN frame stream; flags short and long frames.
// Latency: sclk rise to shift 3 clk, EN rise to valid/frame_err 3 clk; no backpressure (pulses only).
module led_s2p_rx
  import led_s2p_rx_pkg::*;
#(
  parameter int DATA_BITS       = 16,
  parameter int DATA_COUNT_BITS = 5,
  parameter int DIR             = DIR_MSB_FIRST
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sclk,
  input  logic                 sout,
  input  logic                 sclrn,
  input  logic                 EN,
  output logic [DATA_BITS-1:0] PData,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 ovf,
  output logic                 busy
);

  localparam logic [DATA_COUNT_BITS-1:0] FULL_CNT = DATA_COUNT_BITS'(DATA_BITS);

  logic sclk_sync, sclk_rise;
  logic en_sync, en_rise;
  logic sout_s1, sout_s2;
  logic sclrn_s1, sclrn_s2;

  led_s2p_rx_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (sclk),
    .sync (sclk_sync),
    .rise (sclk_rise)
  );

  led_s2p_rx_sync_edge #(.RST_VAL(1'b1)) u_en_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (EN),
    .sync (en_sync),
    .rise (en_rise)
  );

  // sout stage 2 lines up with the sclk rise detection, so the sampled bit is the one
  // that was stable around the serial clock edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sout_s1  <= 1'b0;
      sout_s2  <= 1'b0;
      sclrn_s1 <= 1'b1;
      sclrn_s2 <= 1'b1;
    end else begin
      sout_s1  <= sout;
      sout_s2  <= sout_s1;
      sclrn_s1 <= sclrn;
      sclrn_s2 <= sclrn_s1;
    end
  end

  state_t                     state, state_n;
  logic [DATA_BITS-1:0]       shreg, shreg_n, shifted;
  logic [DATA_COUNT_BITS-1:0] cnt, cnt_n, cnt_inc;
  logic [DATA_BITS-1:0]       pdata_n;
  logic                       valid_n, ferr_n, ovf_n;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      PData     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      PData     <= pdata_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
      ovf       <= ovf_n;
    end
  end

  always_comb begin
    if (DIR == DIR_MSB_FIRST) shifted = {shreg[DATA_BITS-2:0], sout_s2};
    else                      shifted = {sout_s2, shreg[DATA_BITS-1:1]};
  end

  assign cnt_inc = cnt + DATA_COUNT_BITS'(1);

  // The shift is resolved before the EN check so a frame whose last bit arrives
  // together with EN is judged on its post-shift count.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    pdata_n = PData;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    ovf_n   = 1'b0;
    if (!sclrn_s2) begin
      shreg_n = '0;
      cnt_n   = '0;
      state_n = IDLE;
    end else begin
      if (sclk_rise) begin
        case (state)
          IDLE, SHIFT: begin
            shreg_n = shifted;
            cnt_n   = cnt_inc;
            state_n = (cnt_inc == FULL_CNT) ? FULL : SHIFT;
          end
          FULL:    ovf_n   = 1'b1;
          default: state_n = IDLE;
        endcase
      end
      if (en_rise) begin
        if (state_n == FULL) begin
          pdata_n = shreg_n;
          valid_n = 1'b1;
        end else begin
          ferr_n = 1'b1;
        end
        cnt_n   = '0;
        state_n = IDLE;
      end
    end
  end

  assign busy = (state == SHIFT) || (state == FULL);

endmodule

// File: tb/tb_led_s2p_rx.sv
// Directed bench for led_s2p_rx: one MSB-first and one LSB-first instance share the serial stimulus.
module tb_led_s2p_rx;

  logic        clk = 1'b0;
  logic        rstn, sclk, sout, sclrn, en;
  logic [15:0] pdata0, pdata1;
  logic        valid0, ferr0, ovf0, busy0;
  logic        valid1, ferr1, ovf1, busy1;

  int nchecks = 0;
  int nerrors = 0;
  int n_valid = 0, n_ferr = 0, n_ovf = 0, n_valid1 = 0;

  always #5 clk = ~clk;

  led_s2p_rx #(.DATA_BITS(16), .DATA_COUNT_BITS(5), .DIR(0)) dut0 (
    .clk(clk), .rstn(rstn), .sclk(sclk), .sout(sout), .sclrn(sclrn), .EN(en),
    .PData(pdata0), .valid(valid0), .frame_err(ferr0), .ovf(ovf0), .busy(busy0)
  );

  led_s2p_rx #(.DATA_BITS(16), .DATA_COUNT_BITS(5), .DIR(1)) dut1 (
    .clk(clk), .rstn(rstn), .sclk(sclk), .sout(sout), .sclrn(sclrn), .EN(en),
    .PData(pdata1), .valid(valid1), .frame_err(ferr1), .ovf(ovf1), .busy(busy1)
  );

  always @(posedge clk) begin
    #1;
    if (valid0) n_valid++;
    if (ferr0)  n_ferr++;
    if (ovf0)   n_ovf++;
    if (valid1) n_valid1++;
  end

  task automatic clear_counts();
    n_valid = 0; n_ferr = 0; n_ovf = 0; n_valid1 = 0;
  endtask

  task automatic send_bit(input logic b);
    sout = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_msb(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[15-i]);
  endtask

  task automatic send_lsb(input logic [15:0] w);
    for (int i = 0; i < 16; i++) send_bit(w[i]);
  endtask

  task automatic en_pulse();
    en = 1'b1;
    repeat (6) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; sclk = 1'b0; sout = 1'b0; sclrn = 1'b1; en = 1'b0;
    repeat (3) @(negedge clk);
    nchecks++; if (pdata0 !== 16'h0000) begin nerrors++; $display("FAIL reset_pdata0: got %h want 0000", pdata0); end
    nchecks++; if (pdata1 !== 16'h0000) begin nerrors++; $display("FAIL reset_pdata1: got %h want 0000", pdata1); end
    nchecks++; if ({valid0, ferr0, ovf0, busy0} !== 4'b0000) begin nerrors++; $display("FAIL reset_flags0: got %b want 0000", {valid0, ferr0, ovf0, busy0}); end
    nchecks++; if ({valid1, ferr1, ovf1, busy1} !== 4'b0000) begin nerrors++; $display("FAIL reset_flags1: got %b want 0000", {valid1, ferr1, ovf1, busy1}); end
    rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_frame_msb();
    logic [5:0] vmask;
    clear_counts();
    send_msb(16'hA5C3, 16);
    nchecks++; if (busy0 !== 1'b1) begin nerrors++; $display("FAIL msb_busy_full: got %b want 1", busy0); end
    vmask = '0;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid0) vmask[i] = 1'b1;
    end
    en = 1'b0;
    repeat (4) @(negedge clk);
    nchecks++; if (vmask !== 6'b000100) begin nerrors++; $display("FAIL msb_valid_timing: got %b want 000100", vmask); end
    nchecks++; if (pdata0 !== 16'hA5C3) begin nerrors++; $display("FAIL msb_pdata: got %h want a5c3", pdata0); end
    nchecks++; if (pdata1 !== 16'hC3A5) begin nerrors++; $display("FAIL msb_pdata_dir1: got %h want c3a5", pdata1); end
    nchecks++; if (n_ferr !== 0) begin nerrors++; $display("FAIL msb_ferr: got %0d want 0", n_ferr); end
    nchecks++; if (busy0 !== 1'b0) begin nerrors++; $display("FAIL msb_busy_after: got %b want 0", busy0); end
  endtask

  task automatic test_short();
    clear_counts();
    send_msb(16'hFFFF, 10);
    en_pulse();
    nchecks++; if (n_ferr !== 1) begin nerrors++; $display("FAIL short_ferr: got %0d want 1", n_ferr); end
    nchecks++; if (n_valid !== 0) begin nerrors++; $display("FAIL short_valid: got %0d want 0", n_valid); end
    nchecks++; if (pdata0 !== 16'hA5C3) begin nerrors++; $display("FAIL short_pdata: got %h want a5c3", pdata0); end
    nchecks++; if (busy0 !== 1'b0) begin nerrors++; $display("FAIL short_busy: got %b want 0", busy0); end
  endtask

  task automatic test_frame_lsb();
    clear_counts();
    send_lsb(16'h1234);
    en_pulse();
    nchecks++; if (pdata1 !== 16'h1234) begin nerrors++; $display("FAIL lsb_pdata: got %h want 1234", pdata1); end
    nchecks++; if (n_valid1 !== 1) begin nerrors++; $display("FAIL lsb_valid: got %0d want 1", n_valid1); end
    nchecks++; if (pdata0 !== 16'h2C48) begin nerrors++; $display("FAIL lsb_pdata_dir0: got %h want 2c48", pdata0); end
  endtask

  task automatic test_overflow();
    clear_counts();
    send_msb(16'hFFFF, 16);
    nchecks++; if (n_ovf !== 0) begin nerrors++; $display("FAIL ovf_early: got %0d want 0", n_ovf); end
    send_bit(1'b0);
    nchecks++; if (n_ovf !== 1) begin nerrors++; $display("FAIL ovf_17th: got %0d want 1", n_ovf); end
    en_pulse();
    nchecks++; if (pdata0 !== 16'hFFFF) begin nerrors++; $display("FAIL ovf_pdata: got %h want ffff", pdata0); end
    nchecks++; if (n_valid !== 1) begin nerrors++; $display("FAIL ovf_valid: got %0d want 1", n_valid); end
    nchecks++; if (n_ovf !== 1) begin nerrors++; $display("FAIL ovf_total: got %0d want 1", n_ovf); end
  endtask

  task automatic test_clear();
    clear_counts();
    send_msb(16'hAB00, 8);
    sclrn = 1'b0;
    repeat (4) @(negedge clk);
    sclrn = 1'b1;
    repeat (4) @(negedge clk);
    nchecks++; if (busy0 !== 1'b0) begin nerrors++; $display("FAIL clear_busy: got %b want 0", busy0); end
    send_msb(16'h00FF, 16);
    en_pulse();
    nchecks++; if (pdata0 !== 16'h00FF) begin nerrors++; $display("FAIL clear_pdata: got %h want 00ff", pdata0); end
    nchecks++; if (n_valid !== 1) begin nerrors++; $display("FAIL clear_valid: got %0d want 1", n_valid); end
    nchecks++; if (n_ferr + n_ovf !== 0) begin nerrors++; $display("FAIL clear_errs: got %0d want 0", n_ferr + n_ovf); end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    send_msb(16'hFFFF, 5);
    nchecks++; if (busy0 !== 1'b1) begin nerrors++; $display("FAIL rstmid_busy_before: got %b want 1", busy0); end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    nchecks++; if (pdata0 !== 16'h0000) begin nerrors++; $display("FAIL rstmid_pdata: got %h want 0000", pdata0); end
    nchecks++; if ({valid0, ferr0, ovf0, busy0} !== 4'b0000) begin nerrors++; $display("FAIL rstmid_flags: got %b want 0000", {valid0, ferr0, ovf0, busy0}); end
    repeat (10) @(negedge clk);
    nchecks++; if (n_ferr !== 0) begin nerrors++; $display("FAIL rstmid_ferr: got %0d want 0", n_ferr); end
  endtask

  task automatic test_simultaneous();
    clear_counts();
    send_msb(16'h5A0F, 15);
    sout = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    en   = 1'b1;
    repeat (6) @(negedge clk);
    sclk = 1'b0;
    en   = 1'b0;
    repeat (4) @(negedge clk);
    nchecks++; if (n_valid !== 1) begin nerrors++; $display("FAIL simul_valid: got %0d want 1", n_valid); end
    nchecks++; if (n_ferr !== 0) begin nerrors++; $display("FAIL simul_ferr: got %0d want 0", n_ferr); end
    nchecks++; if (pdata0 !== 16'h5A0F) begin nerrors++; $display("FAIL simul_pdata: got %h want 5a0f", pdata0); end

    clear_counts();
    send_msb(16'h1111, 16);
    sclrn = 1'b0;
    en    = 1'b1;
    repeat (6) @(negedge clk);
    en    = 1'b0;
    sclrn = 1'b1;
    repeat (4) @(negedge clk);
    nchecks++; if (n_valid + n_ferr !== 0) begin nerrors++; $display("FAIL clr_en_pulses: got %0d want 0", n_valid + n_ferr); end
    nchecks++; if (pdata0 !== 16'h5A0F) begin nerrors++; $display("FAIL clr_en_pdata: got %h want 5a0f", pdata0); end
    nchecks++; if (busy0 !== 1'b0) begin nerrors++; $display("FAIL clr_en_busy: got %b want 0", busy0); end
  endtask

  initial begin
    test_reset();
    test_frame_msb();
    test_short();
    test_frame_lsb();
    test_overflow();
    test_clear();
    test_reset_mid();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
